// File: rtl/wrr_no_blkmem_if.sv
// Packet tuple and CPU command/response bundle for the WRR rank calculator.
// The master drives packets and CPU commands; the slave (the calculator) drives results.
interface wrr_no_blkmem_if;
  logic        tuple_in_my_pifo_rank_calc_input_VALID;
  logic [12:0] tuple_in_my_pifo_rank_calc_input_DATA;
  logic        tuple_out_my_pifo_rank_calc_output_VALID;
  logic [31:0] tuple_out_my_pifo_rank_calc_output_DATA;
  logic        wire_in_cpu_valid;
  logic [7:0]  wire_in_cpu_index;
  logic        wire_in_cpu_write_sig;
  logic [8:0]  wire_in_cpu_config_write;
  logic        wire_in_cpu_read_sig;
  logic [7:0]  wire_out_cpu_index;
  logic [26:0] wire_out_cpu_val;
  logic        wire_out_cpu_valid;

  modport master (
    output tuple_in_my_pifo_rank_calc_input_VALID, tuple_in_my_pifo_rank_calc_input_DATA,
    output wire_in_cpu_valid, wire_in_cpu_index, wire_in_cpu_write_sig,
    output wire_in_cpu_config_write, wire_in_cpu_read_sig,
    input  tuple_out_my_pifo_rank_calc_output_VALID, tuple_out_my_pifo_rank_calc_output_DATA,
    input  wire_out_cpu_index, wire_out_cpu_val, wire_out_cpu_valid
  );

  modport slave (
    input  tuple_in_my_pifo_rank_calc_input_VALID, tuple_in_my_pifo_rank_calc_input_DATA,
    input  wire_in_cpu_valid, wire_in_cpu_index, wire_in_cpu_write_sig,
    input  wire_in_cpu_config_write, wire_in_cpu_read_sig,
    output tuple_out_my_pifo_rank_calc_output_VALID, tuple_out_my_pifo_rank_calc_output_DATA,
    output wire_out_cpu_index, wire_out_cpu_val, wire_out_cpu_valid
  );
endinterface

// File: rtl/wrr_no_blkmem.sv
// Weighted-round-robin PIFO rank calculator with per-class state held in flip-flops.
// Define WRR_OUTAGE_CATCHUP_EN to let idle classes catch up to the port's last dequeued rank.
module wrr_no_blkmem #(
  parameter int NUM_PORTS   = 5,
  parameter int NUM_CLASSES = 32
) (
  input  logic        clk_dp,
  input  logic        rst_n,
  wrr_no_blkmem_if.slave bus,
  input  logic [31:0] wire_in_last_pkt_info0,
  input  logic [31:0] wire_in_last_pkt_info1,
  input  logic [31:0] wire_in_last_pkt_info2,
  input  logic [31:0] wire_in_last_pkt_info3,
  input  logic [31:0] wire_in_last_pkt_info4
);
  localparam int         NUM_ENTRIES = NUM_PORTS * NUM_CLASSES;
  localparam logic [8:0] ENTRY_LIMIT = 9'(NUM_ENTRIES);

  logic [7:0]  weight_reg   [NUM_ENTRIES];
  logic [7:0]  counter_reg  [NUM_ENTRIES];
  logic [10:0] round_reg    [NUM_ENTRIES];
  logic [1:0]  overflow_reg [NUM_ENTRIES];

  logic        out_valid_reg;
  logic [31:0] out_data_reg;
  logic        cpu_valid_reg;
  logic [7:0]  cpu_index_reg;
  logic [26:0] cpu_val_reg;

  logic [31:0] last_info [5];
  assign last_info[0] = wire_in_last_pkt_info0;
  assign last_info[1] = wire_in_last_pkt_info1;
  assign last_info[2] = wire_in_last_pkt_info2;
  assign last_info[3] = wire_in_last_pkt_info3;
  assign last_info[4] = wire_in_last_pkt_info4;

  // Bits that carry no meaning for the rank computation.
  logic unused_bits;
  assign unused_bits = ^{bus.tuple_in_my_pifo_rank_calc_input_DATA[12:10],
                         bus.wire_in_cpu_config_write[8],
                         last_info[0], last_info[1], last_info[2], last_info[3], last_info[4]};

  logic        port_hit;
  logic [2:0]  port_sel;
  logic [4:0]  cls;
  logic [7:0]  pkt_index;
  logic        pkt_fire;
  logic [12:0] cur_pos;
  logic [12:0] rank_pos;
  logic [7:0]  rank_cnt;
  logic [7:0]  eff_weight;
  logic [8:0]  cnt_inc;
  logic [7:0]  cnt_next;
  logic [12:0] pos_next;
  logic [31:0] rank_data;
  logic [31:0] last_sel;
  logic [12:0] last_pos;
  logic [12:0] pos_diff;

  always_comb begin
    port_hit = 1'b0;
    port_sel = 3'd0;
    // Walk downward so the lowest set port bit is the one left standing.
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (bus.tuple_in_my_pifo_rank_calc_input_DATA[5 + p]) begin
        port_hit = 1'b1;
        port_sel = p[2:0];
      end
    end
    cls       = bus.tuple_in_my_pifo_rank_calc_input_DATA[4:0];
    pkt_index = {port_sel, cls};
    pkt_fire  = bus.tuple_in_my_pifo_rank_calc_input_VALID & port_hit;

    cur_pos  = {overflow_reg[pkt_index], round_reg[pkt_index]};
    rank_pos = cur_pos;
    rank_cnt = counter_reg[pkt_index];
    last_sel = last_info[port_sel];
    last_pos = {last_sel[24:23], last_sel[22:12]};
    pos_diff = last_pos - cur_pos;
`ifdef WRR_OUTAGE_CATCHUP_EN
    // A class that fell behind the port's dequeue point (within half the rank space) jumps forward.
    if (last_sel[31] && (pos_diff != 13'd0) && !pos_diff[12]) begin
      rank_pos = last_pos;
      rank_cnt = 8'd0;
    end
`endif

    eff_weight = (weight_reg[pkt_index] == 8'd0) ? 8'd1 : weight_reg[pkt_index];
    cnt_inc    = {1'b0, rank_cnt} + 9'd1;
    if (cnt_inc >= {1'b0, eff_weight}) begin
      cnt_next = 8'd0;
      pos_next = rank_pos + 13'd1;  // round wrap carries into overflow, which wraps itself
    end else begin
      cnt_next = cnt_inc[7:0];
      pos_next = rank_pos;
    end
    rank_data = {1'b1, 1'b0, cls, rank_pos, 12'd0};
  end

  logic        cpu_in_range;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [26:0] cpu_read_val;

  always_comb begin
    cpu_in_range = ({1'b0, bus.wire_in_cpu_index} < ENTRY_LIMIT);
    cpu_wr       = bus.wire_in_cpu_valid & bus.wire_in_cpu_write_sig & cpu_in_range;
    cpu_rd       = bus.wire_in_cpu_valid & bus.wire_in_cpu_read_sig;
    cpu_read_val = 27'd0;
    if (cpu_in_range) begin
      cpu_read_val = {round_reg[bus.wire_in_cpu_index],
                      weight_reg[bus.wire_in_cpu_index],
                      counter_reg[bus.wire_in_cpu_index]};
    end
  end

  always_ff @(posedge clk_dp or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        weight_reg[e]   <= 8'd1;
        counter_reg[e]  <= 8'd0;
        round_reg[e]    <= 11'd0;
        overflow_reg[e] <= 2'd0;
      end
      out_valid_reg <= 1'b0;
      out_data_reg  <= 32'd0;
      cpu_valid_reg <= 1'b0;
      cpu_index_reg <= 8'd0;
      cpu_val_reg   <= 27'd0;
    end else begin
      out_valid_reg <= bus.tuple_in_my_pifo_rank_calc_input_VALID;
      out_data_reg  <= pkt_fire ? rank_data : 32'd0;
      if (pkt_fire) begin
        counter_reg[pkt_index]  <= cnt_next;
        round_reg[pkt_index]    <= pos_next[10:0];
        overflow_reg[pkt_index] <= pos_next[12:11];
      end
      // Weight writes land after this cycle's packet and read have sampled the old value.
      if (cpu_wr) begin
        weight_reg[bus.wire_in_cpu_index] <= bus.wire_in_cpu_config_write[7:0];
      end
      cpu_valid_reg <= cpu_rd;
      if (cpu_rd) begin
        cpu_index_reg <= bus.wire_in_cpu_index;
        cpu_val_reg   <= cpu_read_val;
      end
    end
  end

  assign bus.tuple_out_my_pifo_rank_calc_output_VALID = out_valid_reg;
  assign bus.tuple_out_my_pifo_rank_calc_output_DATA  = out_data_reg;
  assign bus.wire_out_cpu_valid = cpu_valid_reg;
  assign bus.wire_out_cpu_index = cpu_index_reg;
  assign bus.wire_out_cpu_val   = cpu_val_reg;
endmodule

// File: tb/tb_wrr_no_blkmem.sv
// Directed self-checking bench for the WRR rank calculator.
module tb_wrr_no_blkmem;
  logic        clk;
  logic        rst_n;
  logic [31:0] lpi0, lpi1, lpi2, lpi3, lpi4;
  int vectors;
  int miscompares;

  logic        o_valid;
  logic [31:0] o_data;
  logic        c_valid;
  logic [7:0]  c_index;
  logic [26:0] c_val;

  wrr_no_blkmem_if bus();

  wrr_no_blkmem dut (
    .clk_dp(clk),
    .rst_n(rst_n),
    .bus(bus),
    .wire_in_last_pkt_info0(lpi0),
    .wire_in_last_pkt_info1(lpi1),
    .wire_in_last_pkt_info2(lpi2),
    .wire_in_last_pkt_info3(lpi3),
    .wire_in_last_pkt_info4(lpi4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rank(input logic [4:0] c, input logic [1:0] ov, input logic [10:0] r);
    return {1'b1, 1'b0, c, ov, r, 12'd0};
  endfunction

  function automatic logic [26:0] cval(input logic [10:0] r, input logic [7:0] w, input logic [7:0] cnt);
    return {r, w, cnt};
  endfunction

  task automatic idle_inputs();
    bus.tuple_in_my_pifo_rank_calc_input_VALID = 1'b0;
    bus.tuple_in_my_pifo_rank_calc_input_DATA  = 13'd0;
    bus.wire_in_cpu_valid        = 1'b0;
    bus.wire_in_cpu_index        = 8'd0;
    bus.wire_in_cpu_write_sig    = 1'b0;
    bus.wire_in_cpu_config_write = 9'd0;
    bus.wire_in_cpu_read_sig     = 1'b0;
  endtask

  // One clock of stimulus; outputs are captured 1 time unit after the edge.
  task automatic cycle(input logic pv, input logic [12:0] pd, input logic cv, input logic [7:0] ci,
                       input logic cw, input logic [8:0] cwd, input logic cr);
    @(negedge clk);
    bus.tuple_in_my_pifo_rank_calc_input_VALID = pv;
    bus.tuple_in_my_pifo_rank_calc_input_DATA  = pd;
    bus.wire_in_cpu_valid        = cv;
    bus.wire_in_cpu_index        = ci;
    bus.wire_in_cpu_write_sig    = cw;
    bus.wire_in_cpu_config_write = cwd;
    bus.wire_in_cpu_read_sig     = cr;
    @(posedge clk);
    #1;
    o_valid = bus.tuple_out_my_pifo_rank_calc_output_VALID;
    o_data  = bus.tuple_out_my_pifo_rank_calc_output_DATA;
    c_valid = bus.wire_out_cpu_valid;
    c_index = bus.wire_out_cpu_index;
    c_val   = bus.wire_out_cpu_val;
    idle_inputs();
  endtask

  task automatic pkt(input logic [7:0] port_byte, input logic [4:0] c);
    cycle(1'b1, {port_byte, c}, 1'b0, 8'd0, 1'b0, 9'd0, 1'b0);
  endtask

  task automatic cpu_write(input logic [7:0] idx, input logic [8:0] w);
    cycle(1'b0, 13'd0, 1'b1, idx, 1'b1, w, 1'b0);
  endtask

  task automatic cpu_read(input logic [7:0] idx);
    cycle(1'b0, 13'd0, 1'b1, idx, 1'b0, 9'd0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus.tuple_out_my_pifo_rank_calc_output_VALID, bus.tuple_out_my_pifo_rank_calc_output_DATA,
         bus.wire_out_cpu_valid, bus.wire_out_cpu_index, bus.wire_out_cpu_val} !== 69'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h want 0", {bus.tuple_out_my_pifo_rank_calc_output_VALID,
               bus.tuple_out_my_pifo_rank_calc_output_DATA, bus.wire_out_cpu_valid,
               bus.wire_out_cpu_index, bus.wire_out_cpu_val});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 160; i += 53) begin
      cpu_read(8'(i));
      vectors++;
      if ({c_valid, c_index, c_val} !== {1'b1, 8'(i), cval(11'd0, 8'd1, 8'd0)}) begin
        miscompares++;
        $display("FAIL reset_entry%0d got %h want %h", i, {c_valid, c_index, c_val},
                 {1'b1, 8'(i), cval(11'd0, 8'd1, 8'd0)});
      end
    end
  endtask

  task automatic test_cpu_write();
    logic [7:0] w [160];
    for (int i = 0; i < 160; i++) begin
      w[i] = 8'($urandom_range(0, 254));
      cpu_write(8'(i), {1'b1, w[i]});
      if (i == 0) begin
        vectors++;
        if (c_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL write_no_cpu_valid got %b want 0", c_valid);
        end
      end
    end
    for (int i = 0; i < 160; i++) begin
      cpu_read(8'(i));
      vectors++;
      if ({c_valid, c_index, c_val} !== {1'b1, 8'(i), cval(11'd0, w[i], 8'd0)}) begin
        miscompares++;
        $display("FAIL cpu_readback%0d got %h want %h", i, {c_valid, c_index, c_val},
                 {1'b1, 8'(i), cval(11'd0, w[i], 8'd0)});
      end
    end
    cpu_write(8'd200, 9'h055);
    cpu_read(8'd200);
    vectors++;
    if ({c_valid, c_index, c_val} !== {1'b1, 8'd200, 27'd0}) begin
      miscompares++;
      $display("FAIL cpu_out_of_range got %h want %h", {c_valid, c_index, c_val}, {1'b1, 8'd200, 27'd0});
    end
    cycle(1'b0, 13'd0, 1'b1, 8'd3, 1'b1, 9'h0FF, 1'b1);
    vectors++;
    if ({c_valid, c_val} !== {1'b1, cval(11'd0, w[3], 8'd0)}) begin
      miscompares++;
      $display("FAIL rd_wr_same_cycle got %h want %h", {c_valid, c_val}, {1'b1, cval(11'd0, w[3], 8'd0)});
    end
    cpu_read(8'd3);
    vectors++;
    if (c_val !== cval(11'd0, 8'hFF, 8'd0)) begin
      miscompares++;
      $display("FAIL rd_after_wr got %h want %h", c_val, cval(11'd0, 8'hFF, 8'd0));
    end
  endtask

  task automatic test_normal_wrr();
    do_reset();
    cpu_write(8'd0, 9'd1);
    cpu_write(8'd1, 9'd2);
    for (int k = 0; k < 100; k++) begin
      pkt(8'h01, 5'd0);
      vectors++;
      if ({o_valid, o_data} !== {1'b1, rank(5'd0, 2'd0, 11'(k))}) begin
        miscompares++;
        $display("FAIL wrr_c0_k%0d got %h want %h", k, {o_valid, o_data}, {1'b1, rank(5'd0, 2'd0, 11'(k))});
      end
      pkt(8'h01, 5'd1);
      vectors++;
      if ({o_valid, o_data} !== {1'b1, rank(5'd1, 2'd0, 11'(k / 2))}) begin
        miscompares++;
        $display("FAIL wrr_c1_k%0d got %h want %h", k, {o_valid, o_data}, {1'b1, rank(5'd1, 2'd0, 11'(k / 2))});
      end
    end
    cpu_read(8'd0);
    vectors++;
    if (c_val !== cval(11'd100, 8'd1, 8'd0)) begin
      miscompares++;
      $display("FAIL wrr_final_c0 got %h want %h", c_val, cval(11'd100, 8'd1, 8'd0));
    end
    cpu_read(8'd1);
    vectors++;
    if (c_val !== cval(11'd50, 8'd2, 8'd0)) begin
      miscompares++;
      $display("FAIL wrr_final_c1 got %h want %h", c_val, cval(11'd50, 8'd2, 8'd0));
    end
  endtask

  task automatic test_outage();
    logic [10:0] exp_round;
    logic [10:0] exp_final;
    do_reset();
    cpu_write(8'd0, 9'd1);
    cpu_write(8'd1, 9'd2);
    for (int k = 0; k < 50; k++) pkt(8'h01, 5'd0);
    lpi0 = 32'h8003_1000;
    for (int k = 0; k < 50; k++) begin
`ifdef WRR_OUTAGE_CATCHUP_EN
      exp_round = 11'(49 + k / 2);
`else
      exp_round = 11'(k / 2);
`endif
      pkt(8'h01, 5'd1);
      vectors++;
      if (o_data !== rank(5'd1, 2'd0, exp_round)) begin
        miscompares++;
        $display("FAIL outage_c1_k%0d got %h want %h", k, o_data, rank(5'd1, 2'd0, exp_round));
      end
    end
`ifdef WRR_OUTAGE_CATCHUP_EN
    exp_final = 11'd74;
`else
    exp_final = 11'd25;
`endif
    cpu_read(8'd0);
    vectors++;
    if (c_val !== cval(11'd50, 8'd1, 8'd0)) begin
      miscompares++;
      $display("FAIL outage_final_c0 got %h want %h", c_val, cval(11'd50, 8'd1, 8'd0));
    end
    cpu_read(8'd1);
    vectors++;
    if (c_val !== cval(exp_final, 8'd2, 8'd0)) begin
      miscompares++;
      $display("FAIL outage_final_c1 got %h want %h", c_val, cval(exp_final, 8'd2, 8'd0));
    end
    lpi0 = 32'd0;
  endtask

  task automatic test_overflow();
    do_reset();
    cpu_write(8'd0, 9'd1);
    lpi0 = 32'd0;
    for (int n = 0; n <= 8200; n++) begin
      pkt(8'h01, 5'd0);
      if (n == 0 || n == 2050 || n == 4100 || n == 6150 || n == 8200) begin
        vectors++;
        if (o_data !== rank(5'd0, 2'((n / 2048) % 4), 11'(n % 2048))) begin
          miscompares++;
          $display("FAIL overflow_n%0d got %h want %h", n, o_data, rank(5'd0, 2'((n / 2048) % 4), 11'(n % 2048)));
        end
      end
    end
    cpu_read(8'd0);
    vectors++;
    if (c_val !== cval(11'd9, 8'd1, 8'd0)) begin
      miscompares++;
      $display("FAIL overflow_final got %h want %h", c_val, cval(11'd9, 8'd1, 8'd0));
    end
  endtask

  task automatic test_port_select();
    logic [7:0] bad [3];
    bad[0] = 8'h20; bad[1] = 8'h00; bad[2] = 8'hE0;
    for (int i = 0; i < 3; i++) begin
      pkt(bad[i], 5'd0);
      vectors++;
      if ({o_valid, o_data} !== {1'b1, 32'd0}) begin
        miscompares++;
        $display("FAIL invalid_port_%h got %h want %h", bad[i], {o_valid, o_data}, {1'b1, 32'd0});
      end
    end
    cpu_read(8'd0);
    vectors++;
    if (c_val !== cval(11'd9, 8'd1, 8'd0)) begin
      miscompares++;
      $display("FAIL invalid_port_state got %h want %h", c_val, cval(11'd9, 8'd1, 8'd0));
    end
    pkt(8'h06, 5'd3);
    vectors++;
    if (o_data !== rank(5'd3, 2'd0, 11'd0)) begin
      miscompares++;
      $display("FAIL lowest_port_rank got %h want %h", o_data, rank(5'd3, 2'd0, 11'd0));
    end
    cpu_read(8'd35);
    vectors++;
    if (c_val !== cval(11'd1, 8'd1, 8'd0)) begin
      miscompares++;
      $display("FAIL lowest_port_state got %h want %h", c_val, cval(11'd1, 8'd1, 8'd0));
    end
    pkt(8'h10, 5'd31);
    cpu_read(8'd159);
    vectors++;
    if (c_val !== cval(11'd1, 8'd1, 8'd0)) begin
      miscompares++;
      $display("FAIL last_entry_state got %h want %h", c_val, cval(11'd1, 8'd1, 8'd0));
    end
  endtask

  task automatic test_back_to_back_cpu_pkt();
    cycle(1'b1, {8'h01, 5'd0}, 1'b1, 8'd0, 1'b1, 9'd5, 1'b0);
    vectors++;
    if (o_data !== rank(5'd0, 2'd0, 11'd9)) begin
      miscompares++;
      $display("FAIL wr_pkt_same_rank got %h want %h", o_data, rank(5'd0, 2'd0, 11'd9));
    end
    cpu_read(8'd0);
    vectors++;
    if (c_val !== cval(11'd10, 8'd5, 8'd0)) begin
      miscompares++;
      $display("FAIL wr_pkt_same_state got %h want %h", c_val, cval(11'd10, 8'd5, 8'd0));
    end
    pkt(8'h01, 5'd0);
    cpu_read(8'd0);
    vectors++;
    if (c_val !== cval(11'd10, 8'd5, 8'd1)) begin
      miscompares++;
      $display("FAIL new_weight_used got %h want %h", c_val, cval(11'd10, 8'd5, 8'd1));
    end
    cpu_write(8'd2, 9'd0);
    for (int k = 0; k < 2; k++) begin
      pkt(8'h01, 5'd2);
      vectors++;
      if (o_data !== rank(5'd2, 2'd0, 11'(k))) begin
        miscompares++;
        $display("FAIL zero_weight_k%0d got %h want %h", k, o_data, rank(5'd2, 2'd0, 11'(k)));
      end
    end
  endtask

  task automatic test_reset_midrun();
    for (int k = 0; k < 5; k++) pkt(8'h01, 5'd1);
    @(negedge clk);
    bus.tuple_in_my_pifo_rank_calc_input_VALID = 1'b1;
    bus.tuple_in_my_pifo_rank_calc_input_DATA  = {8'h01, 5'd1};
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.tuple_out_my_pifo_rank_calc_output_VALID, bus.tuple_out_my_pifo_rank_calc_output_DATA} !== 33'd0) begin
      miscompares++;
      $display("FAIL midrun_async_clear got %h want 0",
               {bus.tuple_out_my_pifo_rank_calc_output_VALID, bus.tuple_out_my_pifo_rank_calc_output_DATA});
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.tuple_out_my_pifo_rank_calc_output_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_no_output got %b want 0", bus.tuple_out_my_pifo_rank_calc_output_VALID);
    end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpu_read(8'(i));
      vectors++;
      if (c_val !== cval(11'd0, 8'd1, 8'd0)) begin
        miscompares++;
        $display("FAIL midrun_entry%0d got %h want %h", i, c_val, cval(11'd0, 8'd1, 8'd0));
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b1;
    lpi0 = 32'd0; lpi1 = 32'd0; lpi2 = 32'd0; lpi3 = 32'd0; lpi4 = 32'd0;
    idle_inputs();
    test_reset();
    test_cpu_write();
    test_normal_wrr();
    test_outage();
    test_overflow();
    test_port_select();
    test_back_to_back_cpu_pkt();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wrr_no_blkmem.md
# wrr_no_blkmem

Weighted-round-robin rank calculator for the PIFO scheduler pipeline. Per packet it reads a {port, class} tuple and returns a PIFO rank built from the class's current WRR round and overflow epoch. It updates the per-class state in flip-flops, with no block RAM. A CPU port writes and reads per-class weights and state. Per-port last-dequeued ranks from the PIFO let idle classes catch up to the current round.

## Interface
- NUM_PORTS, 5: ports supported; must be ≤ 8.
- NUM_CLASSES, 32: classes per port; entry index = port*32 + class, 160 entries.
- clk_dp  in  1: single clock for the datapath and the CPU path.
- rst_n  in  1: reset, asynchronous and active-low.
- tuple_in_my_pifo_rank_calc_input_VALID  in  1: packet strobe.
- tuple_in_my_pifo_rank_calc_input_DATA  in  13: [12:5] one-hot port, [4:0] class.
- tuple_out_my_pifo_rank_calc_output_VALID  out  1: result strobe.
- tuple_out_my_pifo_rank_calc_output_DATA  out  32: [31] pifo_valid, [30] 0, [29:25] class, [24:23] overflow, [22:12] round, [11:0] reserved = 0.
- wire_in_last_pkt_info0..4  in  32 each: last dequeued rank of port N, same layout as the output.
- wire_in_cpu_valid  in  1: CPU command strobe.
- wire_in_cpu_index  in  8: entry index.
- wire_in_cpu_write_sig  in  1: write weight.
- wire_in_cpu_config_write  in  9: weight; bits [7:0] used, bit 8 ignored.
- wire_in_cpu_read_sig  in  1: read entry.
- wire_out_cpu_index  out  8: echoed index.
- wire_out_cpu_val  out  27: {round[10:0], config_weight[7:0], counter[7:0]}.
- wire_out_cpu_valid  out  1: read response strobe.

## Operation
- Per-entry state: config_weight (8 bits), counter (8 bits), round (11 bits), overflow (2 bits).
- Port select: the lowest set bit among port bits [4:0].
  - If no bit in [4:0] is set, emit output VALID with the data all zero (pifo_valid = 0) and leave all state unchanged.
- Effective weight: config_weight, or 1 when config_weight is 0.
- Catch-up: if last_pkt_info[port][31] = 1, compare L = its {overflow, round} with C = the class's {overflow, round}.
  - d = (L − C) mod 8192.
  - If 0 < d < 4096, set C = L and counter = 0 before assigning the rank.
- Rank assignment: emit pifo_valid = 1, with class, overflow and round taken from C after any catch-up.
- State update:
  - counter+1; if it reaches the effective weight or more, counter = 0 and round+1.
  - round wraps 2047→0 and increments overflow; overflow wraps 3→0.
- CPU write (valid & write_sig): config_weight[index] = config_write[7:0]. Counter, round and overflow are unchanged.
- CPU read (valid & read_sig): returns {round, config_weight, counter} together with the index.
- Index ≥ 160: a write is ignored; a read returns val = 0 with valid = 1.
- A read and a write in the same cycle: the read returns the pre-write value.
- A CPU write and a packet to the same entry in the same cycle: the packet uses the old weight.

## Timing
- Datapath latency is 1 cycle: the output is registered, and VALID is a 1-cycle pulse per input VALID.
- Back-to-back packets on consecutive cycles, same or different class, must give the same results as spaced packets.
- CPU read latency is 1 cycle. wire_out_cpu_valid pulses only for reads.
- A write is visible to a packet or read in the next cycle.
- Reset values:
  - All outputs 0.
  - Every counter, round and overflow is 0; every config_weight is 1.
- Reset mid-operation clears everything immediately; there is no output on the cycle after the packet.

## Configuration
- WRR_OUTAGE_CATCHUP_EN defined: the catch-up rule is active.
- Not defined: the wire_in_last_pkt_info* inputs are ignored and ranks depend only on the class's own packets.

## Test plan
- CPU write: write random weights 0..254 to all 160 entries, then read each back → config_weight matches and wire_out_cpu_index echoes the index.
- Normal WRR: P0C0 weight 1, P0C1 weight 2; 100 alternating packets per class (port byte 0x01).
  - k-th P0C0 packet → round k.
  - k-th P0C1 packet → round ⌊k/2⌋.
  - Final state: P0C0 round 100, P0C1 round 50, both counters 0.
- Outage (with the macro): after reset, same weights; 50 P0C0 packets, then last_pkt_info0 = 0x80031000 (round 49), then 50 P0C1 packets.
  - First P0C1 rank has round 49.
  - Final state: P0C0 round 50, P0C1 round 74.
- Overflow: P0C0 weight 1, last_pkt_info0 = 0.
  - After 2050 packets → overflow 1, round 2.
  - After 4100 → overflow 2, round 4.
  - After 6150 → overflow 3, round 6.
  - After 8200 → overflow 0, round 8.
- Invalid port: port byte 0x20 → output VALID with data 0; no state changes.
- Reset mid-run: assert rst_n low during a packet burst → outputs go to 0, all rounds are 0 and weights are 1 on readback.
